// File: rtl/de2_pio_pkg.sv
// Shared constants and types for the DE2 parallel input capture port.
// Register window addresses and edge-type encodings.
package de2_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

endpackage

// File: rtl/de2_pio_input_capture_if.sv
// Avalon-MM slave bus bundle for the input capture PIO.
// Master drives strobes/address/data, slave returns readdata.
interface de2_pio_input_capture_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/de2_pio_debounce.sv
// Per-bit synchroniser plus optional tick-sampled debounce.
// Prescaler/debounce exist only when PIO_DEBOUNCE_EN is defined.
module de2_pio_debounce #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             primed_o
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [WIDTH-1:0] meta_q, sync_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic             primed_q, primed_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      stable_q <= '0;
      primed_q <= 1'b0;
    end else begin
      meta_q   <= in_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      primed_q <= primed_d;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] same;
  logic             tick;

  always_comb begin
    tick     = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    same     = ~(sync_q ^ sample_q);
    sample_d = sample_q;
    stable_d = stable_q;
    primed_d = primed_q;
    if (tick) begin
      sample_d = sync_q;
      // first tick adopts the input level outright
      if (!primed_q) begin
        stable_d = sync_q;
        primed_d = 1'b1;
      end else begin
        stable_d = (stable_q & ~same) | (sync_q & same);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      sample_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
    end
  end
`else
  always_comb begin
    stable_d = sync_q;
    primed_d = 1'b1;
  end
`endif

  assign stable_o = stable_q;
  assign primed_o = primed_q;

endmodule

// File: rtl/de2_pio_input_capture.sv
// DE2 switch/key input PIO: debounce, edge capture, masked irq.
// Build option PIO_DEBOUNCE_EN enables the tick-based debounce.
module de2_pio_input_capture
  import de2_pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  de2_pio_input_capture_if.slave   bus,
  input  logic [WIDTH-1:0]         in_port,
  output logic                     irq
);

  localparam edge_type_e ETYPE = edge_type_e'(EDGE_TYPE[1:0]);

  logic [WIDTH-1:0] stable, stable_prev_q;
  logic [WIDTH-1:0] edge_raw, edge_v, clear;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             primed, armed_q;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wdata;

  de2_pio_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .in_i     (in_port),
    .stable_o (stable),
    .primed_o (primed)
  );

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  always_comb begin
    case (ETYPE)
      EDGE_FALLING: edge_raw = ~stable & stable_prev_q;
      EDGE_ANY:     edge_raw = stable ^ stable_prev_q;
      default:      edge_raw = stable & ~stable_prev_q;
    endcase
    // armed_q hides the priming load from the edge detector
    edge_v    = edge_raw & {WIDTH{primed & armed_q}};
    clear     = '0;
    irqmask_d = irqmask_q;
    if (wr_en && bus.address == ADDR_EDGECAP) clear = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == ADDR_IRQMASK) irqmask_d = bus.writedata[WIDTH-1:0];
    edgecap_d = edge_v | (edgecap_q & ~clear);
    irq_d     = |(edgecap_q & irqmask_q);
    unique case (bus.address)
      ADDR_DATA:    rdata_d = 32'(stable);
      ADDR_IRQMASK: rdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: rdata_d = 32'(edgecap_q);
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_prev_q <= '0;
      armed_q       <= 1'b0;
      edgecap_q     <= '0;
      irqmask_q     <= '0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      armed_q       <= primed;
      edgecap_q     <= edgecap_d;
      irqmask_q     <= irqmask_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule
